execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  LEGv8 (ARMv8 subset) execute stage for the single-issue CPU. Contains the main control decoder,
//  the 64-bit ALU, the branch target/decision unit, a small data memory and the write-back register.
//  Sits after instruction decode: decode supplies PC, instruction, register operands and the sign-extended
//  immediate. This stage returns the branch redirect to fetch and the register write-back to decode.
// PARAMETERS
//  DMEM_DEPTH  32  number of 64-bit double words in data memory (power of 2)
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  in_valid     in   1   instruction/operands on the inputs are valid this cycle
//  pc           in   64  address of the current instruction
//  instr        in   32  current instruction word
//  imm          in   64  sign-extended immediate from decode, selected by is_b/is_cbz/is_cbnz
//  data1        in   64  X[instr[9:5]] (Rn)
//  data2        in   64  X[instr[20:16]] when reg2loc=0, else X[instr[4:0]] (Rt)
//  reg2loc      out  1   decode hint: second read port uses Rt (STUR, CBZ, CBNZ)
//  is_b         out  1   unconditional branch decoded
//  is_cbz       out  1   CBZ decoded
//  is_cbnz      out  1   CBNZ decoded
//  branch_addr  out  64  pc + (imm << 2)
//  pc_src       out  1   1 = fetch must take branch_addr next
//  wb_en        out  1   registered: write wb_data to X[wb_addr]
//  wb_addr      out  5   registered destination register
//  wb_data      out  64  registered write-back value
// BEHAVIOUR
//  Decode (combinational, opcode = instr[31:21]); all controls are 0 when in_valid=0 or the opcode is unknown:
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R-type, ALUSrc=reg, RegWrite.
//   ADDI 1001000100x, SUBI 1101000100x: ALUSrc=imm, RegWrite.
//   LDUR 11111000010: ALU add Rn+imm, MemRead, MemtoReg, RegWrite.
//   STUR 11111000000: ALU add Rn+imm, MemWrite, reg2loc=1.
//   CBZ 10110100xxx / CBNZ 10110101xxx: reg2loc=1, is_cbz / is_cbnz.
//   B 000101xxxxx: is_b.
//  ALUOp 2b: 00=add, 01=pass data2, 10=R-type function per opcode, 11=I-type add/sub.
//   Arithmetic is mod 2^64; no flags are produced.
//  Branch (combinational, same cycle): branch_addr = pc + {imm[61:0],2'b00}.
//   pc_src = is_b | (is_cbz & data2==0) | (is_cbnz & data2!=0).
//  Data memory: index = alu_result[3+:log2(DMEM_DEPTH)]; low 3 bits are ignored; upper bits wrap.
//   STUR writes data2 on the clock edge. LDUR reads synchronously.
//  Write-back register, updated every edge:
//   wb_en <= RegWrite & (instr[4:0]!=31); wb_addr <= instr[4:0].
//   wb_data <= MemtoReg ? mem[index] : alu_result.
//   Writes to X31/XZR are suppressed.
//   Result latency is 1 cycle.
//   A load directly after a store to the same index returns the stored value (write-first).
//  Reset (rst_n=0 at an edge): wb_en=0, wb_addr=0, wb_data=0; all memory words cleared to 0.
//   Reset takes priority over any in-flight store or write-back. Branch outputs stay combinational.
// STRUCTURE
//  Package legv8_pkg: 11-bit opcode constants, ALUOp and ALUSrc enums, control-word struct.
//  One sub-module, legv8_control: pure combinational opcode -> control word.
//  ALU, branch unit, data memory and write-back register are inline.
// TESTING
//  1. ADD X1,X2,X3 (0x8B030041), data1=5, data2=7 -> next edge: wb_en=1, wb_addr=1, wb_data=12.
//  2. STUR X4,[X0,#8] with data1=0, imm=8, data2=0xDEAD; then LDUR X5,[X0,#8] -> wb_addr=5, wb_data=0xDEAD, wb_en=1.
//  3. CBZ, pc=0x100, imm=4: data2=0 -> pc_src=1, branch_addr=0x110; data2=1 -> pc_src=0. No wb_en in either case.
//  4. B, pc=0x100, imm=-1 -> pc_src=1, branch_addr=0xFC. SUB with rd=31 -> wb_en=0.
//  5. Unknown opcode or in_valid=0 -> all controls 0, pc_src=0, wb_en=0.
//     rst_n low mid-stream -> wb_* =0 next edge; a subsequent LDUR returns 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcodes, ALU control enums, control word and ALU helper
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Prefixes of opcodes whose low bits belong to the immediate field
  localparam logic [9:0]  OP_ADDI_HI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI_HI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ_HI  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_HI = 8'b10110101;
  localparam logic [5:0]  OP_B_HI    = 6'b000101;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASS  = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_IMM = 1'b1
  } alu_src_e;

  typedef struct packed {
    logic     reg2loc;
    alu_src_e alu_src;
    alu_op_e  alu_op;
    logic     mem_read;
    logic     mem_to_reg;
    logic     mem_write;
    logic     reg_write;
    logic     is_b;
    logic     is_cbz;
    logic     is_cbnz;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg2loc: 1'b0, alu_src: SRC_REG, alu_op: ALU_ADD, mem_read: 1'b0,
    mem_to_reg: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
    is_b: 1'b0, is_cbz: 1'b0, is_cbnz: 1'b0
  };

  function automatic logic [63:0] alu_calc(input alu_op_e op, input logic [10:0] opcode,
                                           input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = a + b;
    case (op)
      ALU_ADD:   r = a + b;
      ALU_PASS:  r = b;
      ALU_RTYPE: begin
        if (opcode == OP_SUB)      r = a - b;
        else if (opcode == OP_AND) r = a & b;
        else if (opcode == OP_ORR) r = a | b;
        else                       r = a + b;
      end
      // opcode[9] is instr[30], the ADDI/SUBI selector
      ALU_ITYPE: r = opcode[9] ? (a - b) : (a + b);
      default:   r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode/fetch facing bundle of the execute stage
interface execute_stage_if;
  logic        in_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] imm;
  logic [63:0] data1;
  logic [63:0] data2;
  logic        reg2loc;
  logic        is_b;
  logic        is_cbz;
  logic        is_cbnz;
  logic [63:0] branch_addr;
  logic        pc_src;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;

  modport slave (
    input  in_valid, pc, instr, imm, data1, data2,
    output reg2loc, is_b, is_cbz, is_cbnz, branch_addr, pc_src, wb_en, wb_addr, wb_data
  );

  modport master (
    output in_valid, pc, instr, imm, data1, data2,
    input  reg2loc, is_b, is_cbz, is_cbnz, branch_addr, pc_src, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/legv8_control.sv
// rtl/legv8_control.sv - combinational opcode to control-word decoder
module legv8_control
  import legv8_pkg::*;
(
  input  logic        in_valid,
  input  logic [10:0] opcode,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    if (in_valid) begin
      if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
        ctrl.alu_op    = ALU_RTYPE;
        ctrl.reg_write = 1'b1;
      end else if (opcode[10:1] == OP_ADDI_HI || opcode[10:1] == OP_SUBI_HI) begin
        ctrl.alu_src   = SRC_IMM;
        ctrl.alu_op    = ALU_ITYPE;
        ctrl.reg_write = 1'b1;
      end else if (opcode == OP_LDUR) begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end else if (opcode == OP_STUR) begin
        ctrl.alu_src   = SRC_IMM;
        ctrl.mem_write = 1'b1;
        ctrl.reg2loc   = 1'b1;
      end else if (opcode[10:3] == OP_CBZ_HI) begin
        ctrl.reg2loc = 1'b1;
        ctrl.alu_op  = ALU_PASS;
        ctrl.is_cbz  = 1'b1;
      end else if (opcode[10:3] == OP_CBNZ_HI) begin
        ctrl.reg2loc = 1'b1;
        ctrl.alu_op  = ALU_PASS;
        ctrl.is_cbnz = 1'b1;
      end else if (opcode[10:5] == OP_B_HI) begin
        ctrl.is_b = 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - LEGv8 execute stage: decode, ALU, branch, data memory, write-back
module execute_stage
  import legv8_pkg::*;
#(
  parameter int DMEM_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  execute_stage_if.slave ex
);

  localparam int IDX_W = $clog2(DMEM_DEPTH);

  ctrl_t             ctrl;
  logic [63:0]       alu_b;
  logic [63:0]       alu_result;
  logic [IDX_W-1:0]  mem_idx;
  logic [63:0]       mem_q [DMEM_DEPTH];
  logic [63:0]       mem_d [DMEM_DEPTH];
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [63:0]       wb_data_q, wb_data_d;
  logic              unused_bits;

  legv8_control u_control (
    .in_valid (ex.in_valid),
    .opcode   (ex.instr[31:21]),
    .ctrl     (ctrl)
  );

  assign alu_b      = (ctrl.alu_src == SRC_IMM) ? ex.imm : ex.data2;
  assign alu_result = alu_calc(ctrl.alu_op, ex.instr[31:21], ex.data1, alu_b);
  // Double-word addressing: byte offset dropped, upper address bits wrap
  assign mem_idx    = alu_result[3 +: IDX_W];
  assign unused_bits = ^{alu_result[63:3+IDX_W], alu_result[2:0], ex.instr[20:5]};

  assign ex.reg2loc     = ctrl.reg2loc;
  assign ex.is_b        = ctrl.is_b;
  assign ex.is_cbz      = ctrl.is_cbz;
  assign ex.is_cbnz     = ctrl.is_cbnz;
  assign ex.branch_addr = ex.pc + {ex.imm[61:0], 2'b00};
  assign ex.pc_src      = ctrl.is_b
                        | (ctrl.is_cbz  & (ex.data2 == 64'd0))
                        | (ctrl.is_cbnz & (ex.data2 != 64'd0));

  always_comb begin
    mem_d = mem_q;
    if (ctrl.mem_write) mem_d[mem_idx] = ex.data2;
  end

  always_comb begin
    wb_en_d   = ctrl.reg_write && (ex.instr[4:0] != 5'd31);
    wb_addr_d = ex.instr[4:0];
    wb_data_d = (ctrl.mem_read && ctrl.mem_to_reg) ? mem_q[mem_idx] : alu_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 64'd0;
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= 64'd0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign ex.wb_en   = wb_en_q;
  assign ex.wb_addr = wb_addr_q;
  assign ex.wb_data = wb_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  execute_stage_if ex_if ();

  execute_stage #(.DMEM_DEPTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic [31:0] ins,
                       input logic [63:0] im, input logic [63:0] d1, input logic [63:0] d2);
    ex_if.in_valid = v;
    ex_if.pc       = p;
    ex_if.instr    = ins;
    ex_if.imm      = im;
    ex_if.data1    = d1;
    ex_if.data2    = d2;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 64'd0, 32'd0, 64'd0, 64'd0, 64'd0);
    tick();
    tick();
    check("reset_wb_en", {63'd0, ex_if.wb_en}, 64'd0);
    check("reset_wb_addr", {59'd0, ex_if.wb_addr}, 64'd0);
    check("reset_wb_data", ex_if.wb_data, 64'd0);
    rst_n = 1'b1;

    // ADD X1,X2,X3
    drive(1'b1, 64'd0, 32'h8B030041, 64'd0, 64'd5, 64'd7);
    check("add_reg2loc", {63'd0, ex_if.reg2loc}, 64'd0);
    check("add_pc_src", {63'd0, ex_if.pc_src}, 64'd0);
    tick();
    check("add_wb_en", {63'd0, ex_if.wb_en}, 64'd1);
    check("add_wb_addr", {59'd0, ex_if.wb_addr}, 64'd1);
    check("add_wb_data", ex_if.wb_data, 64'd12);

    // SUB X6,X2,X3 wraps below zero
    drive(1'b1, 64'd0, 32'hCB030046, 64'd0, 64'd5, 64'd7);
    tick();
    check("sub_wb_addr", {59'd0, ex_if.wb_addr}, 64'd6);
    check("sub_wb_data", ex_if.wb_data, 64'hFFFF_FFFF_FFFF_FFFE);

    drive(1'b1, 64'd0, 32'h8A030047, 64'd0, 64'hF0F0, 64'hFF00);
    tick();
    check("and_wb_data", ex_if.wb_data, 64'hF000);
    drive(1'b1, 64'd0, 32'hAA030048, 64'd0, 64'hF0F0, 64'hFF00);
    tick();
    check("orr_wb_data", ex_if.wb_data, 64'hFFF0);

    drive(1'b1, 64'd0, 32'h91000C49, 64'd3, 64'd10, 64'd0);
    tick();
    check("addi_wb_addr", {59'd0, ex_if.wb_addr}, 64'd9);
    check("addi_wb_data", ex_if.wb_data, 64'd13);
    drive(1'b1, 64'd0, 32'hD1000C4A, 64'd3, 64'd10, 64'd0);
    tick();
    check("subi_wb_data", ex_if.wb_data, 64'd7);

    // STUR X4,[X0,#8] then LDUR X5,[X0,#8]
    drive(1'b1, 64'd0, 32'hF8008004, 64'd8, 64'd0, 64'hDEAD);
    check("stur_reg2loc", {63'd0, ex_if.reg2loc}, 64'd1);
    tick();
    check("stur_wb_en", {63'd0, ex_if.wb_en}, 64'd0);
    drive(1'b1, 64'd0, 32'hF8408005, 64'd8, 64'd0, 64'd0);
    tick();
    check("ldur_wb_en", {63'd0, ex_if.wb_en}, 64'd1);
    check("ldur_wb_addr", {59'd0, ex_if.wb_addr}, 64'd5);
    check("ldur_wb_data", ex_if.wb_data, 64'hDEAD);

    // Address 264 wraps to index 1, same word as address 8
    drive(1'b1, 64'd0, 32'hF8008004, 64'd8, 64'd256, 64'hBEEF);
    tick();
    drive(1'b1, 64'd0, 32'hF8408005, 64'd8, 64'd0, 64'd0);
    tick();
    check("wrap_ldur_data", ex_if.wb_data, 64'hBEEF);
    drive(1'b1, 64'd0, 32'hF8400005, 64'd0, 64'd0, 64'd0);
    tick();
    check("ldur_idx0_data", ex_if.wb_data, 64'd0);

    // CBZ taken / not taken
    drive(1'b1, 64'h100, 32'hB4000082, 64'd4, 64'd0, 64'd0);
    check("cbz_is_cbz", {63'd0, ex_if.is_cbz}, 64'd1);
    check("cbz_taken_pc_src", {63'd0, ex_if.pc_src}, 64'd1);
    check("cbz_branch_addr", ex_if.branch_addr, 64'h110);
    tick();
    check("cbz_taken_wb_en", {63'd0, ex_if.wb_en}, 64'd0);
    drive(1'b1, 64'h100, 32'hB4000082, 64'd4, 64'd0, 64'd1);
    check("cbz_not_taken_pc_src", {63'd0, ex_if.pc_src}, 64'd0);
    tick();
    check("cbz_not_taken_wb_en", {63'd0, ex_if.wb_en}, 64'd0);

    drive(1'b1, 64'h100, 32'hB5000082, 64'd4, 64'd0, 64'd5);
    check("cbnz_is_cbnz", {63'd0, ex_if.is_cbnz}, 64'd1);
    check("cbnz_taken_pc_src", {63'd0, ex_if.pc_src}, 64'd1);
    drive(1'b1, 64'h100, 32'hB5000082, 64'd4, 64'd0, 64'd0);
    check("cbnz_not_taken_pc_src", {63'd0, ex_if.pc_src}, 64'd0);

    // B backwards by one instruction
    drive(1'b1, 64'h100, 32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    check("b_is_b", {63'd0, ex_if.is_b}, 64'd1);
    check("b_pc_src", {63'd0, ex_if.pc_src}, 64'd1);
    check("b_branch_addr", ex_if.branch_addr, 64'hFC);
    tick();
    check("b_wb_en", {63'd0, ex_if.wb_en}, 64'd0);

    // SUB XZR,X2,X3
    drive(1'b1, 64'd0, 32'hCB03005F, 64'd0, 64'd5, 64'd7);
    tick();
    check("sub_xzr_wb_en", {63'd0, ex_if.wb_en}, 64'd0);

    // Unknown opcode
    drive(1'b1, 64'h100, 32'h00000000, 64'd4, 64'd0, 64'd0);
    check("unk_ctrls", {60'd0, ex_if.reg2loc, ex_if.is_b, ex_if.is_cbz, ex_if.is_cbnz}, 64'd0);
    check("unk_pc_src", {63'd0, ex_if.pc_src}, 64'd0);
    tick();
    check("unk_wb_en", {63'd0, ex_if.wb_en}, 64'd0);

    // Valid-looking CBZ with in_valid low
    drive(1'b0, 64'h100, 32'hB4000082, 64'd4, 64'd0, 64'd0);
    check("inval_ctrls", {60'd0, ex_if.reg2loc, ex_if.is_b, ex_if.is_cbz, ex_if.is_cbnz}, 64'd0);
    check("inval_pc_src", {63'd0, ex_if.pc_src}, 64'd0);
    drive(1'b0, 64'd0, 32'h8B030041, 64'd0, 64'd5, 64'd7);
    tick();
    check("inval_wb_en", {63'd0, ex_if.wb_en}, 64'd0);

    // Reset mid-stream overrides a valid ADD and clears memory
    drive(1'b1, 64'd0, 32'h8B030041, 64'd0, 64'd5, 64'd7);
    rst_n = 1'b0;
    tick();
    check("midrst_wb_en", {63'd0, ex_if.wb_en}, 64'd0);
    check("midrst_wb_addr", {59'd0, ex_if.wb_addr}, 64'd0);
    check("midrst_wb_data", ex_if.wb_data, 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 64'd0, 32'hF8408005, 64'd8, 64'd0, 64'd0);
    tick();
    check("postrst_ldur_wb_en", {63'd0, ex_if.wb_en}, 64'd1);
    check("postrst_ldur_data", ex_if.wb_data, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
